wishbone_ram_target: RTL



---
 rtl/wishbone_pkg.sv | 37 +++
 rtl/wishbone_ram_array.sv | 41 ++++
 rtl/wishbone_ram_target.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions: burst code enums, helper sizing function,
// wait-state limit and the RAM target's FSM state type.
package wishbone_pkg;

  // Cycle type identifier codes (carried by the skid buffer, unused by the RAM target)
  typedef enum logic [2:0] {
    WB_CTI_CLASSIC  = 3'b000,
    WB_CTI_CONST    = 3'b001,
    WB_CTI_INCR     = 3'b010,
    WB_CTI_END      = 3'b111
  } wb_cti_e;

  // Burst type extension codes
  typedef enum logic [1:0] {
    WB_BTE_LINEAR = 2'b00,
    WB_BTE_WRAP4  = 2'b01,
    WB_BTE_WRAP8  = 2'b10,
    WB_BTE_WRAP16 = 2'b11
  } wb_bte_e;

  // RAM target access FSM
  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_BUSY = 1'b1
  } wb_state_e;

  // Largest supported number of extra cycles per access
  localparam int WB_MAX_WAIT = 15;

  // Width needed to index a SEL lane; never below one bit
  function automatic int clog2_sel(input int data_width, input int granularity);
    int lanes;
    lanes = data_width / granularity;
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/wishbone_ram_array.sv
// Single-port synchronous RAM with per-lane write enables and a registered
// read port. Written in the plain form that maps onto block RAM.
module wishbone_ram_array
  import wishbone_pkg::*;
#(
  parameter int Depth       = 1024,
  parameter int DataWidth   = 32,
  parameter int Granularity = 8,
  localparam int SelWidth   = DataWidth / Granularity,
  localparam int IdxWidth   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [IdxWidth-1:0]  addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [SelWidth-1:0]  sel_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  // Byte-lane writes, or a registered read when not writing; contents are never reset
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < SelWidth; i++) begin
          if (sel_i[i]) begin
            mem_q[addr_i][i*Granularity +: Granularity] <= wdata_i[i*Granularity +: Granularity];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wishbone_ram_target.sv
// Pipelined Wishbone target in front of a byte-enabled RAM. With no wait
// states every accepted beat is serviced at its accepting edge; otherwise a
// two-state FSM holds the request, stalls for WaitStates cycles and performs
// the access on the last one. Addresses at or beyond Depth end with ERR.
module wishbone_ram_target
  import wishbone_pkg::*;
#(
  parameter int AddressWidth = 16,
  parameter int DataWidth    = 32,
  parameter int Granularity  = 8,
  parameter int TGDWidth     = 1,
  parameter int Depth        = 1024,
  parameter int WaitStates   = 0,
  localparam int SELWidth    = DataWidth / Granularity
) (
  input  logic                    CLK_I,
  input  logic                    RST_N_I,
  input  logic                    CYC_I,
  input  logic                    STB_I,
  input  logic                    WE_I,
  input  logic [AddressWidth-1:0] ADDR_I,
  input  logic [DataWidth-1:0]    DAT_I,
  input  logic [SELWidth-1:0]     SEL_I,
  input  logic [TGDWidth-1:0]     TGD_I,
  output logic [DataWidth-1:0]    DAT_O,
  output logic [TGDWidth-1:0]     TGD_O,
  output logic                    ACK_O,
  output logic                    ERR_O,
  output logic                    RTY_O,
  output logic                    STALL_O
);

  localparam int CntWidth = $clog2(WB_MAX_WAIT + 1);
  localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddressWidth:0] DepthLimit = (AddressWidth + 1)'(Depth);
  localparam logic [CntWidth-1:0]   WaitLoad   = CntWidth'(WaitStates);

  wb_state_e state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Request held while the FSM counts down
  logic [AddressWidth-1:0] req_addr_q, req_addr_d;
  logic [DataWidth-1:0]    req_dat_q, req_dat_d;
  logic [SELWidth-1:0]     req_sel_q, req_sel_d;
  logic                    req_we_q, req_we_d;
  logic [TGDWidth-1:0]     req_tgd_q, req_tgd_d;

  // Termination of the most recent access
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                rsp_rd_q, rsp_rd_d;
  logic [TGDWidth-1:0] rsp_tgd_q, rsp_tgd_d;

  // The access performed at the coming edge, whichever path it came from
  logic                    accept;
  logic                    acc_go;
  logic                    acc_we;
  logic [AddressWidth-1:0] acc_addr;
  logic [DataWidth-1:0]    acc_dat;
  logic [SELWidth-1:0]     acc_sel;
  logic [TGDWidth-1:0]     acc_tgd;
  logic                    acc_in_range;
  logic                    ram_en;
  logic [DataWidth-1:0]    ram_rdata;

  assign STALL_O = (state_q == WB_BUSY);
  assign accept  = CYC_I & STB_I & ~STALL_O;

  // State, counter, held request and termination registers
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q    <= WB_IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_dat_q  <= '0;
      req_sel_q  <= '0;
      req_we_q   <= 1'b0;
      req_tgd_q  <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rsp_rd_q   <= 1'b0;
      rsp_tgd_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      req_dat_q  <= req_dat_d;
      req_sel_q  <= req_sel_d;
      req_we_q   <= req_we_d;
      req_tgd_q  <= req_tgd_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_tgd_q  <= rsp_tgd_d;
    end
  end

  // Next state and access selection; dropping CYC_I abandons anything in flight
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    req_dat_d  = req_dat_q;
    req_sel_d  = req_sel_q;
    req_we_d   = req_we_q;
    req_tgd_d  = req_tgd_q;
    acc_go     = 1'b0;
    acc_we     = req_we_q;
    acc_addr   = req_addr_q;
    acc_dat    = req_dat_q;
    acc_sel    = req_sel_q;
    acc_tgd    = req_tgd_q;

    if (!CYC_I) begin
      state_d = WB_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (accept) begin
            if (WaitStates == 0) begin
              acc_go   = 1'b1;
              acc_we   = WE_I;
              acc_addr = ADDR_I;
              acc_dat  = DAT_I;
              acc_sel  = SEL_I;
              acc_tgd  = TGD_I;
            end else begin
              req_addr_d = ADDR_I;
              req_dat_d  = DAT_I;
              req_sel_d  = SEL_I;
              req_we_d   = WE_I;
              req_tgd_d  = TGD_I;
              cnt_d      = WaitLoad;
              state_d    = WB_BUSY;
            end
          end
        end
        WB_BUSY: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntWidth'(1)) begin
            acc_go  = 1'b1;
            state_d = WB_IDLE;
          end
        end
        default: state_d = WB_IDLE;
      endcase
    end
  end

  // Range check and the termination raised for the cycle after the access
  always_comb begin
    acc_in_range = ({1'b0, acc_addr} < DepthLimit);
    ram_en       = acc_go & acc_in_range;
    ack_d        = acc_go & acc_in_range;
    err_d        = acc_go & ~acc_in_range;
    rsp_rd_d     = acc_go ? ~acc_we : rsp_rd_q;
    rsp_tgd_d    = acc_go ? acc_tgd : rsp_tgd_q;
  end

  wishbone_ram_array #(
    .Depth      (Depth),
    .DataWidth  (DataWidth),
    .Granularity(Granularity)
  ) u_ram (
    .clk_i  (CLK_I),
    .en_i   (ram_en),
    .we_i   (acc_we),
    .addr_i (acc_addr[IdxWidth-1:0]),
    .wdata_i(acc_dat),
    .sel_i  (acc_sel),
    .rdata_o(ram_rdata)
  );

  // Terminations are masked whenever the initiator has let go of the cycle
  assign ACK_O = ack_q & CYC_I;
  assign ERR_O = err_q & CYC_I;
  assign RTY_O = 1'b0;
  assign DAT_O = (ACK_O && rsp_rd_q) ? ram_rdata : '0;
  assign TGD_O = rsp_tgd_q;

endmodule
